// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and address check for the instruction memory arbiter
package imem_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DBG} owner_e;
  localparam int WORD_OFFSET = 2;
  function automatic logic addr_ok(input logic [31:0] addr, input int aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + WORD_OFFSET)) == 32'd0);
  endfunction
endpackage

// File: rtl/imem_addr_chk.sv
// imem_addr_chk: alignment/range check and word index extraction for a byte address
module imem_addr_chk
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic [31:0]           addr,
  output logic                  ok,
  output logic [ADDR_WIDTH-1:0] idx
);
  assign ok  = addr_ok(addr, ADDR_WIDTH);
  assign idx = addr[ADDR_WIDTH+1:WORD_OFFSET];
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction memory between CPU fetch and debug ports
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  output logic                  fetch_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [31:0]           dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
  logic [7:0]            starve_cnt;
  owner_e                resp_owner;
  logic                  resp_err;
  logic                  resp_we;
  logic                  dbg_win;
  logic                  fetch_win;
  logic                  addr_valid;
  logic [31:0]           sel_addr;
  logic [ADDR_WIDTH-1:0] sel_idx;
  assign dbg_win   = !reset && dbg_req && (!fetch_req || starve_cnt == LIM);
  assign fetch_win = !reset && fetch_req && !dbg_win;
  assign sel_addr  = dbg_win ? dbg_addr : fetch_addr;
  imem_addr_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_chk (
    .addr (sel_addr),
    .ok   (addr_valid),
    .idx  (sel_idx)
  );
  assign fetch_gnt = fetch_win;
  assign dbg_gnt   = dbg_win;
  assign mem_en    = (fetch_win || dbg_win) && addr_valid;
  assign mem_we    = mem_en && dbg_win && dbg_we;
  assign mem_addr  = mem_en ? sel_idx : '0;
  assign mem_wdata = mem_we ? dbg_wdata : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      resp_owner <= OWN_NONE;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
    end else begin
      starve_cnt <= (dbg_req && !dbg_win) ? ((starve_cnt == LIM) ? LIM : starve_cnt + 8'd1) : 8'd0;
      resp_owner <= dbg_win ? OWN_DBG : (fetch_win ? OWN_FETCH : OWN_NONE);
      resp_err   <= !addr_valid;
      resp_we    <= dbg_win && dbg_we;
    end
  end
  // responses are masked during reset so a pending one never escapes
  assign fetch_rvalid = !reset && resp_owner == OWN_FETCH;
  assign dbg_rvalid   = !reset && resp_owner == OWN_DBG;
  assign fetch_err    = fetch_rvalid && resp_err;
  assign dbg_err      = dbg_rvalid && resp_err;
  assign fetch_rdata  = (fetch_rvalid && !resp_err) ? mem_rdata : '0;
  assign dbg_rdata    = (dbg_rvalid && !resp_err && !resp_we) ? mem_rdata : '0;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed plus random checks of imem_arbiter against a behavioural model
module tb_imem_arbiter;
  localparam int AW = 4, DW = 32, LIM = 4, DEPTH = 16;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_req = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0]   fetch_addr = '0, dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          fetch_gnt, fetch_rvalid, fetch_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [DW-1:0] fetch_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd = '0;
  logic [DW-1:0] ref_mem [DEPTH];
  int            p_own = 0;
  logic          p_err = 1'b0;
  logic [DW-1:0] p_data = '0;
  int            wait_n = 0;
  int            n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always @(posedge clk) if (mem_en) begin
    rd <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = rd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rst, input logic freq, input logic [31:0] fa,
                      input logic dreq, input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    logic dg, fg, ok, en, we;
    logic [31:0] a;
    int idx;
    @(posedge clk);
    #1;
    reset = rst; fetch_req = freq; fetch_addr = fa;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    dg  = !rst && dreq && (!freq || wait_n == LIM);
    fg  = !rst && freq && !dg;
    a   = dg ? da : fa;
    ok  = (a % 4 == 0) && (a < 4 * DEPTH);
    en  = (dg || fg) && ok;
    we  = en && dg && dwe;
    idx = int'(a / 4);
    #3;
    check("fetch_gnt", 32'(fetch_gnt), 32'(fg));
    check("dbg_gnt", 32'(dbg_gnt), 32'(dg));
    check("mem_en", 32'(mem_en), 32'(en));
    check("mem_we", 32'(mem_we), 32'(we));
    if (en) check("mem_addr", 32'(mem_addr), 32'(idx));
    if (we) check("mem_wdata", mem_wdata, dwd);
    check("fetch_rvalid", 32'(fetch_rvalid), 32'(!rst && p_own == 1));
    check("fetch_err", 32'(fetch_err), 32'(!rst && p_own == 1 && p_err));
    check("fetch_rdata", fetch_rdata, (!rst && p_own == 1) ? p_data : 32'd0);
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(!rst && p_own == 2));
    check("dbg_err", 32'(dbg_err), 32'(!rst && p_own == 2 && p_err));
    check("dbg_rdata", dbg_rdata, (!rst && p_own == 2) ? p_data : 32'd0);
    check("starve_cnt", 32'(dut.starve_cnt), 32'(wait_n));
    if (rst) begin
      p_own  = 0;
      wait_n = 0;
    end else begin
      p_own  = dg ? 2 : (fg ? 1 : 0);
      p_err  = !ok;
      p_data = (ok && !(dg && dwe)) ? ref_mem[idx] : 32'd0;
      if (we) ref_mem[idx] = dwd;
      wait_n = (dreq && !dg) ? ((wait_n < LIM) ? wait_n + 1 : LIM) : 0;
    end
  endtask
  function automatic logic [31:0] rnd_addr();
    int r = $urandom_range(0, 9);
    return (r == 0) ? 32'($urandom) : (32'($urandom_range(0, DEPTH - 1)) * 4 + ((r == 1) ? 32'd2 : 32'd0));
  endfunction
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h00110233;
    mem[1] = 32'h401102B3;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    step(1, 1, 0, 1, 1, 0, 32'h1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0);
    step(0, 1, 32'h8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 32'hC, 1, 0, 32'h10, 0);
    step(0, 1, 32'h2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h40, 32'hBAD0BAD0);
    step(0, 1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      if (i % 2 == 1) step(0, 0, 0, 1, 0, 32'(i * 4), 0);
      else step(0, 1, 32'(i * 4), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), rnd_addr(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rnd_addr(), 32'($urandom));
    step(0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
